// File: rtl/rh_axi4_wr_burst_tracker.sv
// Passive AXI4 write-channel tracker: queues AW commands, counts W beats against AWLEN,
// counts bursts awaiting B and raises sticky protocol errors. Optional macro: RH_AXI4_WR_TIMEOUT_EN.
module rh_axi4_wr_burst_tracker #(
    parameter int IW      = 4,
    parameter int DEPTH   = 8,
    parameter int BCW     = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     AWVALID,
    input  logic                     AWREADY,
    input  logic [7:0]               AWLEN,
    input  logic [IW-1:0]            AWID,
    input  logic                     WVALID,
    input  logic                     WREADY,
    input  logic                     WLAST,
    input  logic                     BVALID,
    input  logic                     BREADY,
    input  logic [IW-1:0]            BID,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   aw_level,
    output logic [7:0]               beat_cnt,
    output logic [BCW-1:0]           b_pending,
    output logic                     err_wlast_early,
    output logic                     err_wlast_missing,
    output logic                     err_aw_overflow,
    output logic                     err_w_no_aw,
    output logic                     err_b_unexpected,
    output logic                     err_timeout
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LVW = PW + 1;
    localparam int EW  = 8 + IW;

    typedef enum logic [0:0] {ST_IDLE, ST_DATA} state_t;

    logic              aw_hs, w_hs, b_hs;
    logic [EW-1:0]     fifo_mem [DEPTH];
    logic [EW-1:0]     head_ent;
    logic [7:0]        head_len;
    logic [IW-1:0]     head_id;
    logic              fifo_empty, fifo_full;
    logic              head_from_fifo, head_valid;
    logic              burst_beat, at_len, burst_end;
    logic              pop, push, bypass_done;
    logic              set_early, set_missing, set_ovf, set_noaw, set_bunexp;
    logic              unused_ok;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVW-1:0]    level_q, level_d;
    logic [7:0]        beat_q, beat_d;
    logic [BCW-1:0]    bpend_q, bpend_d;
    logic              err_early_q, err_early_d;
    logic              err_missing_q, err_missing_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_noaw_q, err_noaw_d;
    logic              err_bunexp_q, err_bunexp_d;

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;
    assign b_hs  = BVALID & BREADY;

    // The head command comes from the queue, or straight from the AW bus when the queue is empty.
    assign fifo_empty     = (level_q == '0);
    assign fifo_full      = (level_q == LVW'(DEPTH));
    assign head_ent       = fifo_mem[rd_ptr_q];
    assign head_from_fifo = ~fifo_empty;
    assign head_valid     = head_from_fifo | aw_hs;
    assign head_len       = head_from_fifo ? head_ent[EW-1:IW] : AWLEN;
    assign head_id        = head_ent[IW-1:0];

    assign burst_beat  = w_hs & head_valid;
    assign at_len      = (beat_q == head_len);
    assign burst_end   = burst_beat & (at_len | WLAST);
    assign pop         = burst_end & head_from_fifo;
    assign bypass_done = burst_end & ~head_from_fifo;
    // A bypassed command that does not finish this cycle is still queued and becomes the head.
    assign push        = aw_hs & ~bypass_done & (~fifo_full | pop);

    assign set_early   = burst_beat & WLAST & (beat_q < head_len);
    assign set_missing = burst_beat & at_len & ~WLAST;
    assign set_ovf     = aw_hs & fifo_full & ~pop;
    assign set_noaw    = w_hs & ~head_valid;

    // BID and the queued ID are carried for diagnostics only.
    assign unused_ok = ^{BID, head_id, (TIMEOUT > 0)};

    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {AWLEN, AWID};
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            beat_q        <= '0;
            bpend_q       <= '0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_noaw_q    <= 1'b0;
            err_bunexp_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            beat_q        <= beat_d;
            bpend_q       <= bpend_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
            err_ovf_q     <= err_ovf_d;
            err_noaw_q    <= err_noaw_d;
            err_bunexp_q  <= err_bunexp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        bpend_d    = bpend_q;
        set_bunexp = 1'b0;

        if (burst_end) begin
            state_d = ST_IDLE;
            beat_d  = '0;
        end else if (burst_beat) begin
            state_d = ST_DATA;
            beat_d  = beat_q + 8'd1;
        end

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        level_d = level_q + LVW'(push) - LVW'(pop);

        // A completion and a B response in the same cycle cancel out.
        if (burst_end && !b_hs) begin
            if (bpend_q != '1) bpend_d = bpend_q + BCW'(1);
        end else if (b_hs && !burst_end) begin
            if (bpend_q == '0) set_bunexp = 1'b1;
            else               bpend_d    = bpend_q - BCW'(1);
        end

        err_early_d   = (err_early_q   & ~err_clr) | set_early;
        err_missing_d = (err_missing_q & ~err_clr) | set_missing;
        err_ovf_d     = (err_ovf_q     & ~err_clr) | set_ovf;
        err_noaw_d    = (err_noaw_q    & ~err_clr) | set_noaw;
        err_bunexp_d  = (err_bunexp_q  & ~err_clr) | set_bunexp;
    end

    always_comb begin
        aw_level          = level_q;
        beat_cnt          = beat_q;
        b_pending         = bpend_q;
        err_wlast_early   = err_early_q;
        err_wlast_missing = err_missing_q;
        err_aw_overflow   = err_ovf_q;
        err_w_no_aw       = err_noaw_q;
        err_b_unexpected  = err_bunexp_q;
    end

`ifdef RH_AXI4_WR_TIMEOUT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic        err_timeout_q, err_timeout_d;

    // Counts cycles without W progress while work is outstanding; holds once it reaches TIMEOUT.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (w_hs) begin
            idle_cnt_d = '0;
        end else if (fifo_empty && state_q == ST_IDLE) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q < 32'(TIMEOUT)) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end
        err_timeout_d = (err_timeout_q & ~err_clr) | (idle_cnt_d >= 32'(TIMEOUT));
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            idle_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            idle_cnt_q    <= idle_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rh_axi4_wr_burst_tracker.sv
// Bench for rh_axi4_wr_burst_tracker: directed scenarios plus randomized traffic against a queue-based model.
module tb_rh_axi4_wr_burst_tracker;

    localparam int IW    = 4;
    localparam int DEPTH = 8;
    localparam int BCW   = 8;
    localparam int BMAX  = (1 << BCW) - 1;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic            ARESETN;
    logic            AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY, err_clr;
    logic [7:0]      AWLEN;
    logic [IW-1:0]   AWID, BID;
    logic [$clog2(DEPTH):0] aw_level;
    logic [7:0]      beat_cnt;
    logic [BCW-1:0]  b_pending;
    logic            err_wlast_early, err_wlast_missing, err_aw_overflow;
    logic            err_w_no_aw, err_b_unexpected, err_timeout;

    rh_axi4_wr_burst_tracker #(.IW(IW), .DEPTH(DEPTH), .BCW(BCW), .TIMEOUT(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN), .AWID(AWID),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
        .err_clr(err_clr),
        .aw_level(aw_level), .beat_cnt(beat_cnt), .b_pending(b_pending),
        .err_wlast_early(err_wlast_early), .err_wlast_missing(err_wlast_missing),
        .err_aw_overflow(err_aw_overflow), .err_w_no_aw(err_w_no_aw),
        .err_b_unexpected(err_b_unexpected), .err_timeout(err_timeout)
    );

    // Reference model: queue of outstanding burst lengths and plain counters.
    int mq[$];
    int m_beats, m_bpend;
    bit m_early, m_missing, m_ovf, m_noaw, m_bunexp;

    int cmp_cnt = 0;
    int mis_cnt = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_errs(input string name, input logic [5:0] exp);
        chk(name, {58'd0, err_wlast_early, err_wlast_missing, err_aw_overflow,
                   err_w_no_aw, err_b_unexpected, err_timeout}, {58'd0, exp});
    endtask

    task automatic model_reset();
        mq.delete();
        m_beats = 0; m_bpend = 0;
        m_early = 0; m_missing = 0; m_ovf = 0; m_noaw = 0; m_bunexp = 0;
    endtask

    task automatic model_step();
        bit aw, w, b, has, from_q, done, popped, byp;
        bit s_early, s_missing, s_ovf, s_noaw, s_bunexp;
        int len, presize;
        if (!ARESETN) begin
            model_reset();
            return;
        end
        aw = AWVALID && AWREADY;
        w  = WVALID && WREADY;
        b  = BVALID && BREADY;
        s_early = 0; s_missing = 0; s_ovf = 0; s_noaw = 0; s_bunexp = 0;
        done = 0; popped = 0; byp = 0; len = 0; from_q = 0; has = 0;
        presize = mq.size();
        if (presize > 0)  begin has = 1; from_q = 1; len = mq[0]; end
        else if (aw)      begin has = 1; len = int'(AWLEN); end
        if (w) begin
            if (!has) s_noaw = 1;
            else begin
                if (WLAST && m_beats < len)   s_early = 1;
                if (m_beats == len && !WLAST) s_missing = 1;
                if (WLAST || m_beats == len) begin
                    done = 1;
                    m_beats = 0;
                    if (from_q) begin void'(mq.pop_front()); popped = 1; end
                    else byp = 1;
                end else m_beats++;
            end
        end
        if (aw && !byp) begin
            if (presize == DEPTH && !popped) s_ovf = 1;
            else mq.push_back(int'(AWLEN));
        end
        if (done && !b) m_bpend = (m_bpend < BMAX) ? m_bpend + 1 : BMAX;
        else if (b && !done) begin
            if (m_bpend == 0) s_bunexp = 1;
            else m_bpend--;
        end
        m_early   = (m_early   && !err_clr) || s_early;
        m_missing = (m_missing && !err_clr) || s_missing;
        m_ovf     = (m_ovf     && !err_clr) || s_ovf;
        m_noaw    = (m_noaw    && !err_clr) || s_noaw;
        m_bunexp  = (m_bunexp  && !err_clr) || s_bunexp;
    endtask

    always @(negedge ACLK) begin
        if (chk_en) begin
            chk("aw_level",  aw_level,  mq.size());
            chk("beat_cnt",  beat_cnt,  m_beats);
            chk("b_pending", b_pending, m_bpend);
            chk("err_wlast_early",   err_wlast_early,   m_early);
            chk("err_wlast_missing", err_wlast_missing, m_missing);
            chk("err_aw_overflow",   err_aw_overflow,   m_ovf);
            chk("err_w_no_aw",       err_w_no_aw,       m_noaw);
            chk("err_b_unexpected",  err_b_unexpected,  m_bunexp);
            chk("err_timeout",       err_timeout,       0);
        end
    end

    task automatic tick();
        @(posedge ACLK);
        model_step();
        #2;
    endtask

    task automatic drv(input bit aw, input int len, input bit w, input bit last,
                       input bit b, input bit clr);
        AWVALID = aw; AWREADY = 1'b1; AWLEN = 8'(len); AWID = IW'($urandom);
        WVALID = w;   WREADY = 1'b1;  WLAST = last;
        BVALID = b;   BREADY = 1'b1;  BID = IW'($urandom);
        err_clr = clr;
    endtask

    task automatic async_reset();
        ARESETN = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        int hl;
        ARESETN = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        model_reset();
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst aw_level", aw_level, 0);
        chk("rst b_pending", b_pending, 0);
        chk_errs("rst errs", 6'b0);
        ARESETN = 1'b1;
        tick();

        // Clean burst len=3, ID=2
        drv(1, 3, 0, 0, 0, 0); AWID = 2; tick();
        chk("t1 aw_level", aw_level, 1);
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 1, k == 3, 0, 0); tick();
            chk("t1 beat_cnt", beat_cnt, (k == 3) ? 0 : k + 1);
        end
        chk("t1 b_pending", b_pending, 1);
        chk("t1 aw_level end", aw_level, 0);
        drv(0, 0, 0, 0, 1, 0); tick();
        chk("t1 b_pending after B", b_pending, 0);
        chk_errs("t1 errs", 6'b0);

        // Early WLAST, then a clean single-beat burst
        drv(1, 3, 0, 0, 0, 0); tick();
        drv(0, 0, 1, 0, 0, 0); tick();
        drv(0, 0, 1, 1, 0, 0); tick();
        chk("t2 err_wlast_early", err_wlast_early, 1);
        chk("t2 aw_level", aw_level, 0);
        chk("t2 b_pending", b_pending, 1);
        drv(1, 0, 0, 0, 0, 0); tick();
        drv(0, 0, 1, 1, 0, 0); tick();
        chk("t2 b_pending 2", b_pending, 2);
        chk("t2 beat_cnt", beat_cnt, 0);
        chk_errs("t2 errs", 6'b100000);

        drv(0, 0, 0, 0, 1, 1); tick();
        chk_errs("t3 clr", 6'b0);
        drv(0, 0, 0, 0, 1, 0); tick();
        chk("t3 b_pending", b_pending, 0);

        // Fill the queue, overflow, then push with a same-cycle pop
        for (int k = 0; k < DEPTH; k++) begin drv(1, 0, 0, 0, 0, 0); tick(); end
        chk("t4 aw_level full", aw_level, DEPTH);
        drv(1, 0, 0, 0, 0, 0); tick();
        chk("t4 overflow", err_aw_overflow, 1);
        chk("t4 level held", aw_level, DEPTH);
        drv(0, 0, 0, 0, 0, 1); tick();
        drv(1, 0, 1, 1, 0, 0); tick();
        chk("t4 push+pop level", aw_level, DEPTH);
        chk_errs("t4 push+pop errs", 6'b0);
        for (int k = 0; k < DEPTH; k++) begin drv(0, 0, 1, 1, 0, 0); tick(); end
        chk("t4 drained level", aw_level, 0);
        chk("t4 b_pending", b_pending, DEPTH + 1);
        for (int k = 0; k <= DEPTH; k++) begin drv(0, 0, 0, 0, 1, 0); tick(); end
        chk("t4 b drained", b_pending, 0);

        // Bypass: AW and W in the same cycle on an empty queue
        drv(1, 0, 1, 1, 0, 0); tick();
        chk("t5 bypass b_pending", b_pending, 1);
        chk("t5 bypass level", aw_level, 0);
        chk_errs("t5 bypass errs", 6'b0);
        drv(1, 2, 1, 0, 0, 0); tick();
        chk("t5 bypass multi level", aw_level, 1);
        chk("t5 bypass multi beat", beat_cnt, 1);
        drv(0, 0, 1, 0, 0, 0); tick();
        drv(0, 0, 1, 1, 0, 0); tick();
        chk("t5 multi b_pending", b_pending, 2);
        chk("t5 multi level", aw_level, 0);
        drv(0, 0, 0, 0, 1, 0); tick();
        tick();

        // W with no AW; B with nothing pending while err_clr is asserted
        drv(0, 0, 1, 1, 0, 0); tick();
        chk_errs("t6 no aw", 6'b000100);
        chk("t6 beat_cnt", beat_cnt, 0);
        drv(0, 0, 0, 0, 1, 1); tick();
        chk_errs("t7 clr vs new err", 6'b000010);
        drv(0, 0, 0, 0, 0, 1); tick();
        chk_errs("t7 cleared", 6'b0);

        // Asynchronous reset mid-burst
        drv(1, 5, 0, 0, 0, 0); tick();
        drv(0, 0, 1, 0, 0, 0); tick();
        tick();
        chk("t8 beat before reset", beat_cnt, 2);
        drv(0, 0, 0, 0, 0, 0);
        async_reset();
        chk("t8 async level", aw_level, 0);
        chk("t8 async beat", beat_cnt, 0);
        chk_errs("t8 async errs", 6'b0);
        tick(); tick();
        ARESETN = 1'b1;
        tick();
        drv(0, 0, 1, 0, 0, 0); tick();
        chk("t8 w after reset", err_w_no_aw, 1);
        drv(0, 0, 0, 0, 0, 1); tick();

        // b_pending saturation
        for (int k = 0; k < BMAX + 5; k++) begin drv(1, 0, 1, 1, 0, 0); tick(); end
        chk("t9 saturated", b_pending, BMAX);
        drv(1, 0, 1, 1, 1, 0); tick();
        chk("t9 net zero", b_pending, BMAX);
        drv(0, 0, 0, 0, 1, 0); tick();
        chk("t9 decrement", b_pending, BMAX - 1);
        drv(0, 0, 0, 0, 0, 0);
        async_reset();
        tick();
        ARESETN = 1'b1;
        tick();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            AWVALID = ($urandom_range(0, 99) < 30);
            AWREADY = ($urandom_range(0, 99) < 75);
            AWLEN   = 8'($urandom_range(0, 3));
            AWID    = IW'($urandom);
            WVALID  = ($urandom_range(0, 99) < 50);
            WREADY  = ($urandom_range(0, 99) < 80);
            if (mq.size() > 0)              hl = mq[0];
            else if (AWVALID && AWREADY)    hl = int'(AWLEN);
            else                            hl = 0;
            WLAST   = (m_beats == hl);
            if ($urandom_range(0, 99) < 10) WLAST = ~WLAST;
            BVALID  = (m_bpend > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 3);
            BREADY  = ($urandom_range(0, 99) < 85);
            BID     = IW'($urandom);
            err_clr = ($urandom_range(0, 99) < 5);
            if (!ARESETN) ARESETN = 1'b1;
            else if ($urandom_range(0, 999) < 2) async_reset();
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
